// File: rtl/rgb2luma_stage.sv
// BT.601 RGB-to-luma conversion stage with delay-matched sync/valid,
// active-pixel position tracking and line/frame geometry checking.
module rgb2luma_stage #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int KR       = 77,
    parameter int KG       = 150,
    parameter int KB       = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  r_i,
    input  logic [7:0]  g_i,
    input  logic [7:0]  b_i,
    input  logic        dv_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic [7:0]  y_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic [10:0] x_index,
    output logic [9:0]  y_index,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [7:0]  KR_W    = KR[7:0];
    localparam logic [7:0]  KG_W    = KG[7:0];
    localparam logic [7:0]  KB_W    = KB[7:0];
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [10:0] PCNT_MAX = 11'd2047;
    localparam logic [9:0]  LCNT_MAX = 10'd1023;

    // Round-to-nearest result is sum[15:8]; any carry into bit 16 clamps to white.
    function automatic logic [7:0] sat_luma(input logic [17:0] sum);
        if (sum[17:16] != 2'b00) begin
            sat_luma = 8'hFF;
        end else begin
            sat_luma = sum[15:8];
        end
    endfunction

    logic [15:0] r_pr;
    logic [15:0] r_pg;
    logic [15:0] r_pb;
    logic [17:0] r_sum;
    logic [7:0]  r_y;
    logic [2:0]  r_dv_sr;
    logic [2:0]  r_hs_sr;
    logic [2:0]  r_vs_sr;

    logic        r_dv_d;
    logic        r_hs_d;
    logic        r_vs_d;
    logic [10:0] r_pcnt;
    logic [9:0]  r_lcnt;
    logic        r_frame_seen;
    logic        r_line_err;
    logic        r_frame_err;

    logic        w_hs_rise;
    logic        w_dv_fall;
    logic        w_vs_rise;
    logic [10:0] w_pcnt_next;
    logic [9:0]  w_lcnt_inc;

    // Three-stage multiply / accumulate / saturate pipeline with matched control delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pr    <= 16'd0;
            r_pg    <= 16'd0;
            r_pb    <= 16'd0;
            r_sum   <= 18'd0;
            r_y     <= 8'd0;
            r_dv_sr <= 3'd0;
            r_hs_sr <= 3'd0;
            r_vs_sr <= 3'd0;
        end else begin
            r_pr    <= {8'd0, KR_W} * {8'd0, r_i};
            r_pg    <= {8'd0, KG_W} * {8'd0, g_i};
            r_pb    <= {8'd0, KB_W} * {8'd0, b_i};
            r_sum   <= {2'b00, r_pr} + {2'b00, r_pg} + {2'b00, r_pb} + 18'd128;
            r_y     <= sat_luma(r_sum);
            r_dv_sr <= {r_dv_sr[1:0], dv_i};
            r_hs_sr <= {r_hs_sr[1:0], hs_i};
            r_vs_sr <= {r_vs_sr[1:0], vs_i};
        end
    end

    // Edge detection on the output-side controls and next-count selection.
    always_comb begin
        w_hs_rise   = r_hs_sr[2] & ~r_hs_d;
        w_dv_fall   = ~r_dv_sr[2] & r_dv_d;
        w_vs_rise   = r_vs_sr[2] & ~r_vs_d;
        w_pcnt_next = r_pcnt;
        w_lcnt_inc  = r_lcnt;
        if (w_hs_rise) begin
            // A pixel coinciding with the line start is the first pixel of the line.
            w_pcnt_next = r_dv_sr[2] ? 11'd1 : 11'd0;
        end else if (r_dv_sr[2] && (r_pcnt != PCNT_MAX)) begin
            w_pcnt_next = r_pcnt + 11'd1;
        end else begin
            w_pcnt_next = r_pcnt;
        end
        if (w_dv_fall && (r_lcnt != LCNT_MAX)) begin
            w_lcnt_inc = r_lcnt + 10'd1;
        end else begin
            w_lcnt_inc = r_lcnt;
        end
    end

    // Position counters and geometry error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dv_d       <= 1'b0;
            r_hs_d       <= 1'b0;
            r_vs_d       <= 1'b0;
            r_pcnt       <= 11'd0;
            r_lcnt       <= 10'd0;
            r_frame_seen <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dv_d     <= r_dv_sr[2];
            r_hs_d     <= r_hs_sr[2];
            r_vs_d     <= r_vs_sr[2];
            r_pcnt     <= w_pcnt_next;
            r_line_err <= w_dv_fall && (r_pcnt != H_ACT);
            if (w_vs_rise) begin
                // The line closing on this same cycle is included in the check.
                r_lcnt       <= 10'd0;
                r_frame_err  <= r_frame_seen && (w_lcnt_inc != V_ACT);
                r_frame_seen <= 1'b1;
            end else begin
                r_lcnt       <= w_lcnt_inc;
                r_frame_err  <= 1'b0;
                r_frame_seen <= r_frame_seen;
            end
        end
    end

    assign y_o       = r_y;
    assign dv_o      = r_dv_sr[2];
    assign hs_o      = r_hs_sr[2];
    assign vs_o      = r_vs_sr[2];
    assign x_index   = r_pcnt;
    assign y_index   = r_lcnt;
    assign line_err  = r_line_err;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_rgb2luma_stage.sv
// Scoreboard bench for rgb2luma_stage: luma values, latency, position and
// geometry error pulses with H_ACTIVE=8, V_ACTIVE=4.
module tb_rgb2luma_stage;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int MKR   = 77;
    localparam int MKG   = 150;
    localparam int MKB   = 29;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  r_i = 8'd0;
    logic [7:0]  g_i = 8'd0;
    logic [7:0]  b_i = 8'd0;
    logic        dv_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [7:0]  y_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic [10:0] x_index;
    logic [9:0]  y_index;
    logic        line_err;
    logic        frame_err;

    typedef struct {
        int y;
        int x;
        int yi;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_lerr = 0;
    int   n_ferr = 0;

    rgb2luma_stage #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .KR(MKR), .KG(MKG), .KB(MKB)
    ) dut (
        .clk(clk), .rst(rst),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .x_index(x_index), .y_index(y_index),
        .line_err(line_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_y(int r, int g, int b);
        int s;
        s = (MKR * r + MKG * g + MKB * b + 128) >> 8;
        if (s > 255) s = 255;
        return s;
    endfunction

    // Output monitor: pops the scoreboard on every valid output pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (line_err)  n_lerr++;
                if (frame_err) n_ferr++;
                if (dv_o) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: dv_o=1 y_o=%0d, expected no output", y_o);
                    end else begin
                        e = sb.pop_front();
                        if (y_o !== e.y[7:0]) begin
                            errors++;
                            $display("FAIL luma: got %0d expected %0d", y_o, e.y);
                        end
                        checks++;
                        if (cyc - e.cyc !== 3) begin
                            errors++;
                            $display("FAIL latency: got %0d expected 3", cyc - e.cyc);
                        end
                        if (e.x >= 0) begin
                            checks++;
                            if (x_index !== e.x[10:0]) begin
                                errors++;
                                $display("FAIL x_index: got %0d expected %0d", x_index, e.x);
                            end
                        end
                        if (e.yi >= 0) begin
                            checks++;
                            if (y_index !== e.yi[9:0]) begin
                                errors++;
                                $display("FAIL y_index: got %0d expected %0d", y_index, e.yi);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic drive(input int r, input int g, input int b, input bit dv,
                         input bit hs, input bit vs, input int ex, input int eyi);
        @(posedge clk);
        #1;
        r_i  = r[7:0];
        g_i  = g[7:0];
        b_i  = b[7:0];
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
        if (dv) sb.push_back('{model_y(r, g, b), ex, eyi, cyc});
    endtask

    task automatic idle();
        drive(0, 0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        ok = (sb.size() == 0);
    endtask

    task automatic send_line(input int npix, input int line_no);
        drive(0, 0, 0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle();
        for (int i = 0; i < npix; i++)
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  1'b1, 1'b0, 1'b0, i, line_no);
        idle();
        idle();
    endtask

    task automatic send_vs();
        drive(0, 0, 0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (y_o !== 8'd0) begin
            errors++; $display("FAIL reset_y: got %0d expected 0", y_o);
        end
        checks++;
        if ({dv_o, hs_o, vs_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {dv_o, hs_o, vs_o});
        end
        checks++;
        if (x_index !== 11'd0) begin
            errors++; $display("FAIL reset_x: got %0d expected 0", x_index);
        end
        checks++;
        if (y_index !== 10'd0) begin
            errors++; $display("FAIL reset_yidx: got %0d expected 0", y_index);
        end
        checks++;
        if ({line_err, frame_err} !== 2'b00) begin
            errors++; $display("FAIL reset_err: got %b expected 00", {line_err, frame_err});
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_colors();
        bit ok;
        int px[5][3] = '{'{255, 255, 255}, '{255, 0, 0}, '{0, 255, 0},
                         '{0, 0, 255}, '{100, 50, 200}};
        int fixed_y[5] = '{255, 77, 149, 29, 82};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (model_y(px[i][0], px[i][1], px[i][2]) != fixed_y[i]) begin
                errors++;
                $display("FAIL color_model %0d: got %0d expected %0d", i,
                         model_y(px[i][0], px[i][1], px[i][2]), fixed_y[i]);
            end
            drive(px[i][0], px[i][1], px[i][2], 1'b1, 1'b0, 1'b0, -1, -1);
            repeat (3) idle();
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL colors_drain: %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_line(8, -1);
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_drain: %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_frames();
        bit ok;
        n_lerr = 0;
        n_ferr = 0;
        send_vs();
        for (int l = 0; l < V_ACT; l++) send_line(H_ACT, l);
        send_vs();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL frames_drain: %0d pending, expected 0", sb.size());
        end
        checks++;
        if (n_lerr != 0) begin
            errors++; $display("FAIL frames_line_err: got %0d pulses expected 0", n_lerr);
        end
        checks++;
        if (n_ferr != 0) begin
            errors++; $display("FAIL frames_frame_err: got %0d pulses expected 0", n_ferr);
        end
    endtask

    task automatic test_short_frame();
        bit ok;
        n_lerr = 0;
        n_ferr = 0;
        send_line(H_ACT, 0);
        send_line(H_ACT - 1, 1);
        send_line(H_ACT, 2);
        send_vs();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL short_drain: %0d pending, expected 0", sb.size());
        end
        checks++;
        if (n_lerr != 1) begin
            errors++; $display("FAIL short_line_err: got %0d pulses expected 1", n_lerr);
        end
        checks++;
        if (n_ferr != 1) begin
            errors++; $display("FAIL short_frame_err: got %0d pulses expected 1", n_ferr);
        end
    endtask

    task automatic test_mid_reset();
        drive(0, 0, 0, 1'b0, 1'b1, 1'b0, -1, -1);
        idle();
        for (int i = 0; i < 5; i++)
            drive(200, 100, 50, 1'b1, 1'b0, 1'b0, i, -1);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({y_o, dv_o, hs_o, vs_o, x_index, y_index, line_err, frame_err} !== 34'd0) begin
            errors++;
            $display("FAIL async_reset: y=%0d dv=%b x=%0d yi=%0d, expected all 0",
                     y_o, dv_o, x_index, y_index);
        end
        sb.delete();
        @(posedge clk);
        #1;
        dv_i = 1'b0;
        r_i  = 8'd0;
        g_i  = 8'd0;
        b_i  = 8'd0;
        rst  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (dv_o !== 1'b0 || x_index !== 11'd0) begin
                errors++;
                $display("FAIL post_reset %0d: dv_o=%b x=%0d expected 0 and 0", i, dv_o, x_index);
            end
        end
    endtask

    initial begin
        test_reset();
        test_colors();
        test_back_to_back();
        test_frames();
        test_short_frame();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
